// File: rtl/cirno_pkg.sv
// cirno_pkg: shared types, opcode constants and widths for the Cirno CPU
package cirno_pkg;
    localparam int PC_W   = 9;
    localparam int DATA_W = 8;
    localparam int INST_W = 9;

    typedef enum logic [2:0] {
        T_NONE     = 3'd0,
        T_ALU      = 3'd1,
        T_IMM_CTRL = 3'd2,
        T_MOVE     = 3'd3,
        T_REG_CTRL = 3'd4,
        T_STORE    = 3'd5,
        T_LOAD     = 3'd6
    } inst_type_e;

    localparam logic [3:0] F_ADD  = 4'd0;
    localparam logic [3:0] F_SUB  = 4'd1;
    localparam logic [3:0] F_AND  = 4'd2;
    localparam logic [3:0] F_OR   = 4'd3;
    localparam logic [3:0] F_XOR  = 4'd4;
    localparam logic [3:0] F_CMP  = 4'd5;
    localparam logic [3:0] F_SH   = 4'd6;
    localparam logic [3:0] F_INCC = 4'd7;
    localparam logic [3:0] F_ANDI = 4'd8;
    localparam logic [3:0] F_SHRI = 4'd9;
    localparam logic [3:0] F_SHLI = 4'd10;
    localparam logic [3:0] F_MV   = 4'd11;
    localparam logic [3:0] F_CTRL = 4'd12;
    localparam logic [3:0] F_RSVD = 4'd13;
    localparam logic [3:0] F_ST   = 4'd14;
    localparam logic [3:0] F_LD   = 4'd15;

    localparam logic [1:0] OP_JMPI  = 2'd0;
    localparam logic [1:0] OP_BEQI  = 2'd1;
    localparam logic [1:0] OP_MOVIL = 2'd2;
    localparam logic [1:0] OP_MOVIH = 2'd3;

    localparam logic [1:0] C_JMP  = 2'd0;
    localparam logic [1:0] C_BEQ  = 2'd1;
    localparam logic [1:0] C_NIL  = 2'd2;
    localparam logic [1:0] C_HALT = 2'd3;

    function automatic logic [PC_W-1:0] sext6(input logic [5:0] v);
        return {{(PC_W-6){v[5]}}, v};
    endfunction
endpackage

// File: rtl/cirno_alu_core.sv
// cirno_alu_core: combinational R-type datapath; st/ld/mv pass y through
module cirno_alu_core
    import cirno_pkg::*;
(
    input  logic [3:0]        funct,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [1:0]        imm,
    input  logic              carry,
    output logic [DATA_W-1:0] result,
    output logic              carry_next,
    output logic              eq
);
    logic [2:0] sh_i;
    assign sh_i = {1'b0, imm} + 3'd1;
    assign eq = x == y;
    always_comb begin
        result = '0;
        carry_next = carry;
        case (funct)
            F_ADD:  {carry_next, result} = {1'b0, x} + {1'b0, y};
            F_SUB: begin
                result = x - y;
                carry_next = x < y;
            end
            F_AND:  result = x & y;
            F_OR:   result = x | y;
            F_XOR:  result = x ^ y;
            F_SH:   result = y[3] ? x >> y[2:0] : x << y[2:0];
            F_INCC: {carry_next, result} = {1'b0, x} + {8'b0, carry};
            F_ANDI: result = x & {6'b0, imm};
            F_SHRI: result = x >> sh_i;
            F_SHLI: result = x << sh_i;
            F_MV, F_ST, F_LD: result = y;
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/cirno_fetch_exec.sv
// cirno_fetch_exec: PC, instruction register, decode registers and execute stage
// sequenced by fetch/decode/alu strobes (init > fetch > decode > alu).
module cirno_fetch_exec
    import cirno_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic [PC_W-1:0]   start_addr,
    input  logic              fetch_en,
    input  logic              decode_en,
    input  logic              alu_en,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic [2:0]        inst_type,
    output logic [3:0]        funct,
    output logic [1:0]        r1,
    output logic [1:0]        r2,
    output logic [5:0]        immediate,
    output logic              wb,
    output logic [DATA_W-1:0] result,
    output logic              cmp_flag,
    output logic              carry,
    output logic              done
);
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst_q;
    inst_type_e        type_q, d_type;
    logic              itype_q;
    logic              d_i, d_wb, d_jump, d_halt;
    logic [1:0]        d_op2;
    logic [3:0]        d_f;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c, alu_eq;

    assign imem_addr = pc;
    assign inst_type = type_q;

    always_comb begin
        d_i = inst_q[8];
        d_op2 = inst_q[7:6];
        d_f = inst_q[7:4];
        d_type = d_i ? (d_op2[1] ? T_MOVE : T_IMM_CTRL)
               : d_f <= F_SHLI ? T_ALU
               : d_f == F_MV ? T_MOVE
               : d_f == F_CTRL ? (inst_q[1] ? T_IMM_CTRL : T_REG_CTRL)
               : d_f == F_ST ? T_STORE
               : d_f == F_LD ? T_LOAD : T_IMM_CTRL;
        d_wb = d_i ? d_op2[1] : (d_type == T_ALU && d_f != F_CMP) || d_f == F_MV || d_f == F_LD;
        d_jump = d_i && (d_op2 == OP_JMPI || (d_op2 == OP_BEQI && cmp_flag));
        d_halt = !d_i && d_f == F_CTRL && inst_q[1:0] == C_HALT;
    end

    cirno_alu_core u_alu (
        .funct      (funct),
        .x          (x),
        .y          (y),
        .imm        (immediate[1:0]),
        .carry      (carry),
        .result     (alu_res),
        .carry_next (alu_c),
        .eq         (alu_eq)
    );

    // I-type ops report funct as {00,op2}; itype_q tells movil/movih apart from mv
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
            inst_q <= '0;
            type_q <= T_NONE;
            itype_q <= 1'b0;
            funct <= '0;
            r1 <= '0;
            r2 <= '0;
            immediate <= '0;
            wb <= 1'b0;
            result <= '0;
            cmp_flag <= 1'b0;
            carry <= 1'b0;
            done <= 1'b0;
        end else if (init) begin
            pc <= start_addr;
            done <= 1'b0;
        end else if (!done) begin
            if (fetch_en) begin
                inst_q <= imem_rdata;
                pc <= pc + 9'd1;
            end else if (decode_en) begin
                type_q <= d_type;
                itype_q <= d_i;
                funct <= d_i ? {2'b00, d_op2} : d_f;
                r1 <= d_i ? 2'b00 : inst_q[3:2];
                r2 <= d_i ? 2'b00 : inst_q[1:0];
                immediate <= d_i ? inst_q[5:0] : {4'b0, inst_q[1:0]};
                wb <= d_wb;
                if (d_jump) pc <= pc + sext6(inst_q[5:0]);
                if (d_halt) done <= 1'b1;
            end else if (alu_en) begin
                case (type_q)
                    T_ALU: begin
                        if (funct == F_CMP) cmp_flag <= alu_eq;
                        else result <= alu_res;
                        if (funct == F_ADD || funct == F_SUB || funct == F_INCC) carry <= alu_c;
                    end
                    T_MOVE: result <= itype_q ? (funct[0] ? {immediate[3:0], x[3:0]} : {x[7:4], immediate[3:0]}) : alu_res;
                    T_REG_CTRL: if (r2 == C_JMP || cmp_flag) pc <= {1'b0, x};
                    T_STORE, T_LOAD: result <= alu_res;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cirno_fetch_exec.sv
// tb_cirno_fetch_exec: scoreboard bench; an arithmetic reference model queues
// expected architectural state after every cycle and a monitor compares it.
module tb_cirno_fetch_exec;
    logic       clk, rst_n, init, fetch_en, decode_en, alu_en;
    logic [8:0] start_addr, imem_addr, imem_rdata;
    logic [7:0] x, y, result;
    logic [2:0] inst_type;
    logic [3:0] funct;
    logic [1:0] r1, r2;
    logic [5:0] immediate;
    logic       wb, cmp_flag, carry, done;

    cirno_fetch_exec dut (
        .clk(clk), .rst_n(rst_n), .init(init), .start_addr(start_addr),
        .fetch_en(fetch_en), .decode_en(decode_en), .alu_en(alu_en),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .x(x), .y(y),
        .inst_type(inst_type), .funct(funct), .r1(r1), .r2(r2),
        .immediate(immediate), .wb(wb), .result(result),
        .cmp_flag(cmp_flag), .carry(carry), .done(done)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct {
        int pc, ty, f, r1, r2, imm, wb, res, cmp, cy, dn;
    } snap_t;
    snap_t exp_q[$];
    int tests = 0, fails = 0;

    int m_pc, m_ty, m_f, m_r1, m_r2, m_imm, m_wb, m_res, m_cmp, m_cy, m_dn, m_itype;
    logic [8:0] m_inst;

    task automatic m_reset();
        m_pc = 0; m_ty = 0; m_f = 0; m_r1 = 0; m_r2 = 0; m_imm = 0; m_wb = 0;
        m_res = 0; m_cmp = 0; m_cy = 0; m_dn = 0; m_itype = 0; m_inst = '0;
    endtask

    task automatic m_decode();
        int s, op2;
        if (m_inst[8]) begin
            op2 = int'(m_inst[7:6]);
            m_itype = 1; m_f = op2; m_r1 = 0; m_r2 = 0; m_imm = int'(m_inst[5:0]);
            m_ty = (op2 < 2) ? 2 : 3;
            m_wb = (op2 >= 2) ? 1 : 0;
            s = (m_imm >= 32) ? m_imm - 64 : m_imm;
            if (op2 == 0 || (op2 == 1 && m_cmp == 1)) m_pc = (m_pc + s + 512) % 512;
        end else begin
            m_itype = 0;
            m_f = int'(m_inst[7:4]); m_r1 = int'(m_inst[3:2]); m_r2 = int'(m_inst[1:0]);
            m_imm = m_r2;
            if (m_f <= 10) m_ty = 1;
            else if (m_f == 11) m_ty = 3;
            else if (m_f == 12) m_ty = (m_r2 < 2) ? 4 : 2;
            else if (m_f == 13) m_ty = 2;
            else if (m_f == 14) m_ty = 5;
            else m_ty = 6;
            m_wb = ((m_f <= 10 && m_f != 5) || m_f == 11 || m_f == 15) ? 1 : 0;
            if (m_f == 12 && m_r2 == 3) m_dn = 1;
        end
    endtask

    task automatic m_exec(int xv, int yv);
        int s, sh;
        case (m_ty)
            1: case (m_f)
                0: begin s = xv + yv; m_res = s % 256; m_cy = (s > 255) ? 1 : 0; end
                1: begin m_res = (xv - yv + 256) % 256; m_cy = (xv < yv) ? 1 : 0; end
                2: m_res = xv & yv;
                3: m_res = xv | yv;
                4: m_res = xv ^ yv;
                5: m_cmp = (xv == yv) ? 1 : 0;
                6: begin sh = yv % 8; m_res = ((yv & 8) != 0) ? xv >> sh : (xv << sh) % 256; end
                7: begin s = xv + m_cy; m_res = s % 256; m_cy = (s > 255) ? 1 : 0; end
                8: m_res = xv & m_imm;
                9: m_res = xv >> (m_imm + 1);
                default: m_res = (xv << (m_imm + 1)) % 256;
            endcase
            3: if (m_itype == 1) m_res = (m_f == 2) ? (xv & 240) | (m_imm & 15) : ((m_imm & 15) * 16) | (xv & 15);
               else m_res = yv;
            4: if (m_r2 == 0 || m_cmp == 1) m_pc = xv;
            5, 6: m_res = yv;
            default: ;
        endcase
    endtask

    task automatic push();
        snap_t e;
        e.pc = m_pc; e.ty = m_ty; e.f = m_f; e.r1 = m_r1; e.r2 = m_r2; e.imm = m_imm;
        e.wb = m_wb; e.res = m_res; e.cmp = m_cmp; e.cy = m_cy; e.dn = m_dn;
        exp_q.push_back(e);
    endtask

    task automatic step(bit ini, bit fe, bit de, bit ae, logic [8:0] sa, logic [8:0] rd, logic [7:0] xv, logic [7:0] yv);
        @(negedge clk);
        init = ini; fetch_en = fe; decode_en = de; alu_en = ae;
        start_addr = sa; imem_rdata = rd; x = xv; y = yv;
        @(posedge clk);
        #1;
        init = 0; fetch_en = 0; decode_en = 0; alu_en = 0;
        if (ini) begin
            m_pc = int'(sa); m_dn = 0;
        end else if (m_dn == 0) begin
            if (fe) begin m_inst = rd; m_pc = (m_pc + 1) % 512; end
            else if (de) m_decode();
            else if (ae) m_exec(int'(xv), int'(yv));
        end
        push();
    endtask

    task automatic do_init(logic [8:0] sa);  step(1, 0, 0, 0, sa, 9'h0, 8'h0, 8'h0); endtask
    task automatic do_fetch(logic [8:0] rd); step(0, 1, 0, 0, 9'h0, rd, 8'h0, 8'h0); endtask
    task automatic do_dec();                 step(0, 0, 1, 0, 9'h0, 9'h0, 8'h0, 8'h0); endtask
    task automatic do_alu(logic [7:0] xv, logic [7:0] yv); step(0, 0, 0, 1, 9'h0, 9'h0, xv, yv); endtask
    task automatic do_inst(logic [8:0] rd, logic [7:0] xv, logic [7:0] yv);
        do_fetch(rd); do_dec(); do_alu(xv, yv);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        #1 rst_n = 0;
        #2 rst_n = 1;
        m_reset();
        push();
    endtask

    task automatic chk(string n, int a, int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    initial begin
        snap_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("imem_addr", int'(imem_addr), e.pc);
                chk("inst_type", int'(inst_type), e.ty);
                chk("funct", int'(funct), e.f);
                chk("r1", int'(r1), e.r1);
                chk("r2", int'(r2), e.r2);
                chk("immediate", int'(immediate), e.imm);
                chk("wb", int'(wb), e.wb);
                chk("result", int'(result), e.res);
                chk("cmp_flag", int'(cmp_flag), e.cmp);
                chk("carry", int'(carry), e.cy);
                chk("done", int'(done), e.dn);
            end
        end
    end

    initial begin
        int r;
        rst_n = 0; init = 0; fetch_en = 0; decode_en = 0; alu_en = 0;
        start_addr = '0; imem_rdata = '0; x = '0; y = '0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        push();
        do_init(9'd5);
        do_inst(9'b0_0000_0110, 8'hF0, 8'h20);
        rst_pulse();
        do_init(9'd5);
        do_inst(9'b0_0000_0110, 8'hF0, 8'h20);
        do_inst(9'b0_0101_0000, 8'h07, 8'h07);
        do_init(9'd9);
        do_fetch(9'b1_01_111110); do_dec();
        do_inst(9'b0_0101_0000, 8'h07, 8'h08);
        do_init(9'd9);
        do_fetch(9'b1_01_111110); do_dec();
        do_inst(9'b0_1100_0100, 8'h40, 8'h00);
        do_inst(9'b0_1100_0101, 8'h55, 8'h00);
        do_inst(9'b1_11_000101, 8'h0A, 8'h00);
        do_inst(9'b1_10_001100, 8'hA3, 8'h00);
        do_inst(9'b0_1001_0001, 8'h80, 8'h00);
        do_inst(9'b0_0001_0110, 8'h10, 8'h20);
        do_inst(9'b0_0111_0000, 8'hFF, 8'h00);
        do_inst(9'b0_0110_0001, 8'h81, 8'h0B);
        do_inst(9'b0_1111_1001, 8'h00, 8'h3C);
        do_fetch(9'b0_1100_0011); do_dec();
        do_fetch(9'h1FF);
        do_alu(8'h12, 8'h34);
        do_init(9'd0);
        do_init(9'd511);
        do_fetch(9'b1_00_000011);
        step(0, 1, 1, 1, 9'h0, 9'h0AB, 8'h11, 8'h22);
        step(1, 1, 1, 1, 9'd100, 9'h0AB, 8'h11, 8'h22);
        do_fetch(9'b1_00_100000); do_dec();
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 199);
            if (r == 0) rst_pulse();
            else step(r < 10, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 2) == 0, 9'($urandom), 9'($urandom),
                      8'($urandom), 8'($urandom));
        end
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
